vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: consumes the hsync/vsync/rgb stream a screen top-level drives and recovers pixel coordinates, an active-video qualifier and lock status. Used in loopback against endscreen/game screens for self-check and frame capture, and as the front end of any frame-grabber. Optionally computes a per-frame CRC of active pixels so benches and on-board checks can compare rendered screens (win/lose/home) without storing frames.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, pixels between active end and sync assertion
- H_RETRACE, 96, hsync width in pixels
- H_BACK, 48, pixels after sync; H_TOTAL = sum = 800
- V_DISPLAY, 480; V_FRONT, 10; V_RETRACE, 2; V_BACK, 33; V_TOTAL = 525
- SYNC_ACTIVE, 1'b1, asserted level of hsync/vsync
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- clk_100MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- p_tick  in  1  pixel-rate enable (one clk_100MHz cycle per pixel)
- hsync, vsync  in  1  sync inputs, sampled only when p_tick=1
- rgb  in  12  pixel data, sampled with p_tick
- x, y  out  10  recovered coordinates
- de  out  1  active video: locked && x<H_DISPLAY && y<V_DISPLAY
- pix_rgb  out  12  rgb registered alongside x/y/de
- locked  out  1  timing lock
- frame_start  out  1  one-clk pulse when locked and (x,y) becomes (0,0)
- frame_count  out  16  locked frames seen, wraps
- err_count  out  8  timing errors, saturating at 255
- frame_crc  out  16  CRC of last completed frame (macro-dependent)
- crc_valid  out  1  one-clk pulse when frame_crc updates

## Operation
- Sync sample: on p_tick, register hsync/vsync; assertion edge = previous sample deasserted, current asserted.
- X counter: free-runs on p_tick, 0..H_TOTAL-1 wrap. On hsync edge loaded with H_SYNC_START = H_DISPLAY+H_FRONT (656).
- Y counter: increments when x wraps to 0, wraps at V_TOTAL. On vsync edge loaded with V_SYNC_START = V_DISPLAY+V_FRONT (490).
- Before first hsync edge after reset: x,y held 0 (h_seen=0). Before first vsync edge: y held 0.
- Line error: hsync edge while h_seen and predicted x != 656. Frame error: vsync edge while v_seen and (predicted y != 490 or predicted x != 0). Counters resync to the edge value regardless.
- Lock FSM, states ACQUIRE / LOCKED:
  - ACQUIRE: good_frames counts vsync edges with no error since previous vsync edge; at LOCK_FRAMES -> LOCKED.
  - LOCKED: any line/frame error -> ACQUIRE, good_frames=0, locked drops in the same update.
  - Every error increments err_count (saturating) in either state.
- frame_count increments on each frame_start.
- Simultaneous hsync and vsync edges on one p_tick: both loads apply; both checks evaluated.

## Timing
- All outputs registered; x, y, de, pix_rgb, locked reflect the p_tick sample one clk_100MHz cycle later and hold between p_ticks.
- hsync edge sampled at tick N: x=656 visible after tick N.
- frame_start and crc_valid are single clk_100MHz-cycle pulses, coincident with the x/y update they mark.
- No p_tick: all state holds indefinitely; no timeout.
- Reset: x=0, y=0, de=0, pix_rgb=0, locked=0, frame_start=0, frame_count=0, err_count=0, frame_crc=0, crc_valid=0, FSM=ACQUIRE, h_seen=v_seen=0. Mid-frame reset discards all state; lock re-acquired from fresh edges.

## Configuration
- VGA_SYNC_DECODER_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over the 12-bit pix_rgb of every de=1 pixel in raster order, 12 bits per update; at the sample where locked and y wraps to 0 (x=0, y=0), frame_crc <= accumulator, crc_valid pulses, accumulator reinitialises. Frame interrupted by loss of lock: no crc_valid for it.
- Not defined: no CRC logic; frame_crc constant 0, crc_valid constant 0.

## Test plan
- Feed two good 640x480 frames from vga_controller with p_tick -> locked rises when y reaches 490 on 2nd vsync edge; first frame_start after; frame_count=1; err_count=0.
- Locked, hsync edge shifted +1 pixel in one line -> err_count=1, locked=0 same cycle, x=656 after edge; relocks after 2 clean frames.
- Start stream mid-frame (x=300, y=200) -> x/y hold 0 until first edges, no error counted for first edges, lock after LOCK_FRAMES clean frames.
- Constant rgb=12'hF00 (win screen) with CRC_EN -> crc_valid each frame, identical frame_crc across frames; change one pixel -> frame_crc differs; without macro frame_crc=0.
- Assert reset for one clk at y=100 while locked -> all outputs reset values next cycle; relock requires fresh edges.
- Hold p_tick low 1000 cycles -> x, y, locked, pix_rgb unchanged; no pulses.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Purpose: recovers x/y, active-video, lock and frame statistics from a VGA hsync/vsync/rgb stream.
// Latency: one clk_100MHz cycle after each p_tick sample; outputs hold between p_ticks.
// Backpressure: none; the stream is consumed at p_tick rate. Optional frame CRC via VGA_SYNC_DECODER_CRC_EN.
module vga_sync_decoder #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_RETRACE   = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_RETRACE   = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SS      = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] V_SS      = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] H_ACT     = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT     = 10'(V_DISPLAY);
    localparam logic [3:0] GOOD_LAST = 4'(LOCK_FRAMES - 1);

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } lock_state_t;

    lock_state_t state, state_nxt;
    logic [3:0]  good_frames, good_nxt;

    logic        hs_q, vs_q;
    logic        h_seen, v_seen;
    logic        err_since;

    logic        hs_edge, vs_edge, vs_take;
    logic [9:0]  x_pred, y_pred, x_nxt, y_nxt;
    logic        line_err, frame_err, any_err, frame_clean;
    logic        err_since_nxt, locked_nxt, fs_nxt, de_nxt;

    // Edge detection, free-running prediction and resync on the sync edges.
    always_comb begin
        hs_edge = (hsync == SYNC_ACTIVE) && (hs_q != SYNC_ACTIVE);
        vs_edge = (vsync == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
        // vsync is ignored until the line timing is known
        vs_take = vs_edge && h_seen;

        x_pred = '0;
        y_pred = '0;
        if (h_seen) begin
            x_pred = (x == X_LAST) ? '0 : x + 10'd1;
            y_pred = y;
            if (v_seen && (x == X_LAST)) begin
                y_pred = (y == Y_LAST) ? '0 : y + 10'd1;
            end
        end

        line_err  = hs_edge && h_seen && (x_pred != H_SS);
        frame_err = vs_edge && v_seen && ((y_pred != V_SS) || (x_pred != '0));
        any_err   = line_err || frame_err;

        frame_clean   = vs_take && !err_since && !any_err;
        err_since_nxt = vs_take ? 1'b0 : (err_since || any_err);

        x_nxt = hs_edge ? H_SS : x_pred;
        y_nxt = vs_take ? V_SS : y_pred;
    end

    // Lock FSM: next state.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        case (state)
            ACQUIRE: begin
                if (any_err) begin
                    good_nxt = '0;
                end else if (frame_clean) begin
                    if (good_frames >= GOOD_LAST) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good_frames + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ACQUIRE;
                good_nxt  = '0;
            end
        endcase
    end

    // Lock FSM: state register, advanced only on pixel ticks.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state       <= ACQUIRE;
            good_frames <= '0;
        end else if (p_tick) begin
            state       <= state_nxt;
            good_frames <= good_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        locked_nxt = (state_nxt == LOCKED);
        fs_nxt     = locked_nxt && (x_nxt == '0) && (y_nxt == '0);
        de_nxt     = locked_nxt && (x_nxt < H_ACT) && (y_nxt < V_ACT);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            // previous sample treated as asserted: a fresh deassertion must be seen first
            hs_q        <= SYNC_ACTIVE;
            vs_q        <= SYNC_ACTIVE;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            err_since   <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_start <= 1'b0;
            if (p_tick) begin
                hs_q        <= hsync;
                vs_q        <= vsync;
                h_seen      <= h_seen | hs_edge;
                v_seen      <= v_seen | vs_take;
                err_since   <= err_since_nxt;
                x           <= x_nxt;
                y           <= y_nxt;
                de          <= de_nxt;
                pix_rgb     <= rgb;
                frame_start <= fs_nxt;
                if (fs_nxt) begin
                    frame_count <= frame_count + 16'd1;
                end
                if (any_err && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

`ifdef VGA_SYNC_DECODER_CRC_EN
    function automatic logic [15:0] crc16_step12(input logic [15:0] crc, input logic [11:0] dat);
        logic [15:0] r;
        r = crc;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ dat[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    logic [15:0] crc_acc, crc_upd;
    logic        crc_armed;

    // de/pix_rgb are the registered pixel of the previous tick
    always_comb begin
        crc_upd = de ? crc16_step12(crc_acc, pix_rgb) : crc_acc;
    end

    // A frame is only reported when lock was held from its first pixel to the next frame start.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            crc_acc   <= 16'hFFFF;
            crc_armed <= 1'b0;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (p_tick) begin
                if (fs_nxt) begin
                    if (crc_armed) begin
                        frame_crc <= crc_upd;
                        crc_valid <= 1'b1;
                    end
                    crc_acc   <= 16'hFFFF;
                    crc_armed <= 1'b1;
                end else begin
                    crc_acc <= crc_upd;
                    if (!locked_nxt) begin
                        crc_armed <= 1'b0;
                    end
                end
            end
        end
    end
`else
    assign frame_crc = '0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized bench for vga_sync_decoder on a reduced raster (24x15 total, 16x8 active).
// Every cycle is compared against a frame-level reference model kept here.
module tb_vga_sync_decoder;

    localparam int HD = 16, HF = 2, HR = 3, HB = 3;
    localparam int VD = 8, VF = 2, VR = 2, VB = 3;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int HSS = HD + HF;
    localparam int VSS = VD + VF;
    localparam int LF = 2;

    logic        clk_100MHz = 1'b0;
    logic        reset, p_tick, hsync, vsync;
    logic [11:0] rgb;
    logic [9:0]  x, y;
    logic        de, locked, frame_start, crc_valid;
    logic [11:0] pix_rgb;
    logic [15:0] frame_count, frame_crc;
    logic [7:0]  err_count;

    vga_sync_decoder #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_RETRACE(HR), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_RETRACE(VR), .V_BACK(VB),
        .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(LF)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick),
        .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .x(x), .y(y), .de(de), .pix_rgb(pix_rgb), .locked(locked),
        .frame_start(frame_start), .frame_count(frame_count),
        .err_count(err_count), .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_x, m_y, m_good, m_ec, m_fc;
    bit          m_hs, m_vs, m_hseen, m_vseen, m_lock, m_errs, m_de, m_fs, m_cv, m_armed;
    logic [11:0] m_pix;
    logic [15:0] m_acc, m_crc;

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c ^ {d, 4'h0};
        for (int k = 0; k < 12; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_good = 0; m_ec = 0; m_fc = 0;
        m_hs = 1; m_vs = 1; m_hseen = 0; m_vseen = 0; m_lock = 0; m_errs = 0;
        m_de = 0; m_fs = 0; m_cv = 0; m_armed = 0; m_pix = '0;
        m_acc = 16'hFFFF; m_crc = '0;
    endtask

    task automatic model_step(input bit hs, input bit vs, input logic [11:0] d);
        bit he, ve, vtake, err;
        int px, py;
        he = hs && !m_hs;
        ve = vs && !m_vs;
        m_hs = hs;
        m_vs = vs;
        vtake = ve && m_hseen;
        px = 0;
        py = 0;
        if (m_hseen) begin
            px = (m_x + 1) % HT;
            py = m_y;
            if (m_vseen && px == 0) py = (m_y + 1) % VT;
        end
        err = (he && m_hseen && px != HSS) || (ve && m_vseen && (py != VSS || px != 0));
        if (he) begin m_hseen = 1; px = HSS; end
        if (vtake) begin m_vseen = 1; py = VSS; end
        m_x = px;
        m_y = py;
        if (err) begin
            if (m_ec < 255) m_ec++;
            m_lock = 0;
            m_good = 0;
        end
        if (vtake) begin
            if (!err && !m_errs && !m_lock) begin
                m_good++;
                if (m_good >= LF) begin m_lock = 1; m_good = 0; end
            end
            m_errs = 0;
        end else if (err) begin
            m_errs = 1;
        end
        if (m_de) m_acc = crc_ref(m_acc, m_pix);
        m_fs = m_lock && m_x == 0 && m_y == 0;
        m_cv = 0;
        if (m_fs) begin
            m_fc = (m_fc + 1) % 65536;
            if (m_armed) begin m_crc = m_acc; m_cv = 1; end
            m_acc = 16'hFFFF;
            m_armed = 1;
        end else if (!m_lock) begin
            m_armed = 0;
        end
        m_de = m_lock && m_x < HD && m_y < VD;
        m_pix = d;
    endtask

    logic [15:0] crc_q[$];

    task automatic cycle(input bit pt, input bit hs, input bit vs, input logic [11:0] d, input bit rst);
        p_tick = pt; hsync = hs; vsync = vs; rgb = d; reset = rst;
        @(posedge clk_100MHz);
        if (rst) model_reset();
        else if (pt) model_step(hs, vs, d);
        else begin m_fs = 0; m_cv = 0; end
        @(negedge clk_100MHz);
        chk("x", 32'(x), 32'(m_x));
        chk("y", 32'(y), 32'(m_y));
        chk("de", 32'(de), 32'(m_de));
        chk("pix_rgb", 32'(pix_rgb), 32'(m_pix));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("err_count", 32'(err_count), 32'(m_ec));
`ifdef VGA_SYNC_DECODER_CRC_EN
        chk("frame_crc", 32'(frame_crc), 32'(m_crc));
        chk("crc_valid", 32'(crc_valid), 32'(m_cv));
`else
        chk("frame_crc", 32'(frame_crc), 32'h0);
        chk("crc_valid", 32'(crc_valid), 32'h0);
`endif
        if (crc_valid) crc_q.push_back(frame_crc);
    endtask

    // Generator: raster position plus rgb source (0 random, 1 constant red, 2 red with one green pixel)
    int gy = 0;
    int rgb_mode = 0;

    task automatic send_px(input int gx, input int slip);
        bit hs, vs;
        logic [11:0] d;
        hs = (gx >= HSS + slip) && (gx < HSS + slip + HR);
        vs = (gy >= VSS) && (gy < VSS + VR);
        case (rgb_mode)
            0: d = 12'($urandom);
            1: d = 12'hF00;
            default: d = (gx == 3 && gy == 2) ? 12'h0F0 : 12'hF00;
        endcase
        repeat ($urandom_range(0, 2)) cycle(0, 1'($urandom), 1'($urandom), 12'($urandom), 0);
        cycle(1, hs, vs, d, 0);
    endtask

    task automatic send_range(input int x0, input int x1, input int slip);
        for (int gx = x0; gx < x1; gx++) send_px(gx, slip);
    endtask

    task automatic end_line();
        gy = (gy + 1) % VT;
    endtask

    task automatic send_line(input int slip);
        send_range(0, HT + slip, slip);
        end_line();
    endtask

    task automatic send_frame();
        repeat (VT) send_line(0);
    endtask

    initial begin
        model_reset();
        reset = 1; p_tick = 0; hsync = 0; vsync = 0; rgb = '0;
        @(negedge clk_100MHz);
        repeat (3) cycle(0, 0, 0, 12'h0, 1);
        chk("rst_x", 32'(x), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_frame_count", 32'(frame_count), 0);

        // Clean stream from the origin: lock at the second vsync edge.
        gy = 0;
        send_frame();
        repeat (VSS) send_line(0);
        send_px(0, 0);
        chk("lock_2nd_vsync", 32'(locked), 1);
        chk("y_at_vsync", 32'(y), VSS);
        send_range(1, HT, 0);
        end_line();
        while (gy != 0) send_line(0);
        send_px(0, 0);
        chk("first_frame_start", 32'(frame_start), 1);
        chk("frame_count_one", 32'(frame_count), 1);
        chk("no_errors", 32'(err_count), 0);
        send_range(1, HT, 0);
        end_line();
        repeat (2) send_frame();

        // One late hsync while locked.
        repeat (3) send_line(0);
        send_range(0, HSS + 2, 1);
        chk("slip_err_count", 32'(err_count), 1);
        chk("slip_unlock", 32'(locked), 0);
        chk("slip_x_resync", 32'(x), HSS);
        send_range(HSS + 2, HT + 1, 1);
        end_line();
        repeat (3) send_frame();
        chk("relock", 32'(locked), 1);
        chk("relock_err_count", 32'(err_count), 1);

        // Random early/late lines.
        for (int i = 0; i < 3 * VT; i++) begin
            int r;
            r = $urandom_range(0, 9);
            send_line(r == 0 ? -1 : (r == 1 ? 1 : 0));
        end
        repeat (3) send_frame();

        // Mid-frame reset while locked; stream resumes mid-line.
        while (gy != 5) send_line(0);
        send_range(0, 7, 0);
        cycle(0, 0, 0, 12'h0, 1);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_x", 32'(x), 0);
        chk("mid_rst_frame_count", 32'(frame_count), 0);
        send_range(7, HSS, 0);
        chk("hold_x_no_edge", 32'(x), 0);
        chk("hold_y_no_edge", 32'(y), 0);
        send_range(HSS, HT, 0);
        end_line();
        repeat (3) send_frame();
        chk("reacquired", 32'(locked), 1);
        chk("reacquired_err_count", 32'(err_count), 0);

        // Long p_tick stall: everything holds.
        for (int i = 0; i < 1000; i++) cycle(0, 1'($urandom), 1'($urandom), 12'($urandom), 0);

        // Constant screen twice, then one altered pixel.
        while (gy != 0) send_line(0);
        rgb_mode = 1;
        repeat (2) send_frame();
        rgb_mode = 2;
        send_frame();
        rgb_mode = 0;
        send_px(0, 0);
`ifdef VGA_SYNC_DECODER_CRC_EN
        chk("crc_events", 32'(crc_q.size() >= 3), 1);
        if (crc_q.size() >= 3) begin
            chk("crc_same_screen", 32'(crc_q[crc_q.size() - 3] == crc_q[crc_q.size() - 2]), 1);
            chk("crc_pixel_change", 32'(crc_q[crc_q.size() - 2] != crc_q[crc_q.size() - 1]), 1);
        end
`else
        chk("crc_disabled", 32'(frame_crc), 0);
        chk("crc_no_events", 32'(crc_q.size()), 0);
`endif
        send_range(1, HT, 0);
        end_line();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
